// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues PC fetches over req/gnt/rvalid and buffers words for decode.
// Optional misaligned-PC detection is enabled with `define FETCH_MISALIGN_CHECK_EN.
module fetch_queue #(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        instr_misalign_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  out_q, out_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wr_q, rd_q;
    logic [QW-1:0]  aw_q, ar_q;
    logic [31:0]    data_q [DEPTH];
    logic [31:0]    pcs_q  [DEPTH];
    logic [31:0]    aq_q   [MAX_OUTSTANDING];

    logic credit, issue_ok, req, accept, rsp, push, pop;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
    endfunction

    // Credit covers both in-flight requests and buffered words so the FIFO cannot overflow
    assign credit   = (int'(out_q) < MAX_OUTSTANDING)
                   && ((int'(out_q) + int'(cnt_q)) < DEPTH);
    assign issue_ok = (state_q == RUN) && !redirect_i && credit;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign;
    assign misalign = (pc_i[1:0] != 2'b00);
    assign req      = issue_ok && !misalign;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instr_misalign_o <= 1'b0;
        else if (redirect_i)
            instr_misalign_o <= 1'b0;
        else if (issue_ok && misalign)
            instr_misalign_o <= 1'b1;
    end
`else
    assign req = issue_ok;
`endif

    assign imem_req_o    = rst && req;
    assign imem_addr_o   = pc_i;
    assign accept        = imem_req_o && imem_gnt_i;
    assign pc_stall_o    = !rst || !(accept || redirect_i);
    assign rsp           = imem_rvalid_i && (out_q != '0);
    assign push          = (state_q == RUN) && !redirect_i && rsp;
    assign instr_valid_o = (cnt_q != '0);
    assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
    assign instr_o       = instr_valid_o ? data_q[rd_q] : '0;
    assign instr_pc_o    = instr_valid_o ? pcs_q[rd_q] : '0;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        if (redirect_i) begin
            drop_d  = out_q - CW'(rsp);
            out_d   = drop_d;
            cnt_d   = '0;
            state_d = (drop_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    out_d = out_q + CW'(accept) - CW'(rsp);
                    cnt_d = cnt_q + CW'(push) - CW'(pop);
                end
                FLUSH: begin
                    cnt_d = cnt_q - CW'(pop);
                    if (rsp) begin
                        drop_d = drop_q - CW'(1);
                        out_d  = out_q - CW'(1);
                        if (drop_q == CW'(1))
                            state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            out_q   <= '0;
            drop_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            aw_q    <= '0;
            ar_q    <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            if (redirect_i) begin
                wr_q <= '0;
                rd_q <= '0;
                aw_q <= '0;
                ar_q <= '0;
            end else begin
                if (push)
                    wr_q <= wr_q + PW'(1);
                if (pop)
                    rd_q <= rd_q + PW'(1);
                if (accept)
                    aw_q <= q_next(aw_q);
                if (push)
                    ar_q <= q_next(ar_q);
            end
        end
    end

    // Storage needs no reset: head outputs are gated by the registered count
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= imem_rdata_i;
            pcs_q[wr_q]  <= aq_q[ar_q];
        end
        if (accept)
            aq_q[aw_q] <= pc_i;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues read requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PCs in a small FIFO for decode.
- Drives the PC register's hold (stall) control.
- Discards stale in-flight responses on a taken-branch redirect.

Parameters:
- DEPTH, 2, instruction FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum granted-but-unreturned memory requests (≤ DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- pc_i  in  32  current PC from PC register.
- redirect_i  in  1  PCsrc: PC loads branch target at next edge.
- pc_stall_o  out  1  1 = PC register must hold its value this cycle.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (= pc_i while imem_req_o=1).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid (in-order responses).
- imem_rdata_i  in  32  read data.
- instr_valid_o  out  1  FIFO head valid.
- instr_o  out  32  FIFO head instruction.
- instr_pc_o  out  32  FIFO head PC.
- instr_ready_i  in  1  decode accepts head.

Behaviour:
- Reset (rst=0, async): state=RUN; FIFO, address queue, outstanding_cnt and drop_cnt cleared. Outputs: imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0.
- imem_addr_o=pc_i and pc_stall_o are combinational. During reset pc_stall_o=1.
- States: RUN and FLUSH.
- Issue condition (RUN only): !redirect_i && outstanding_cnt < MAX_OUTSTANDING && (outstanding_cnt + fifo_count) < DEPTH.
  - imem_req_o equals the issue condition, combinationally.
  - The memory side tolerates req being withdrawn without a gnt.
- Accept: imem_req_o && imem_gnt_i. On accept, pc_i is pushed into the address queue and outstanding_cnt increments.
- pc_stall_o = !(accept || redirect_i). The PC advances only on an accepted fetch or a redirect.
- Response in RUN: on imem_rvalid_i, pop the address queue and push {pc, imem_rdata_i} into the FIFO; outstanding_cnt decrements.
  - The credit rule guarantees the FIFO never overflows.
  - Accept and response in the same cycle leave outstanding_cnt unchanged.
- Response with outstanding_cnt=0: ignored, no state change. This covers a reset taken mid-transaction.
- FIFO head is registered: instr_valid_o rises the cycle after the pushing rvalid. Pop on instr_valid_o && instr_ready_i.
- Simultaneous push and pop at full: allowed. Count is unchanged and order is preserved.
- Minimum latency: accept at cycle N, rvalid at N+1, instr_valid_o at N+2.
- Redirect (redirect_i=1, any state):
  - No request that cycle.
  - FIFO flushed at the edge, so instr_valid_o=0 next cycle. A pop in the same cycle is irrelevant.
  - Address queue cleared.
  - drop_cnt <= outstanding_cnt − imem_rvalid_i, and outstanding_cnt <= drop_cnt. The response in that cycle is discarded.
  - Next state is FLUSH if the new drop_cnt ≠ 0, else RUN.
- FLUSH:
  - No requests; pc_stall_o=1 unless redirect_i.
  - Each rvalid decrements drop_cnt and outstanding_cnt; data is discarded.
  - Go to RUN at the edge where drop_cnt goes 1→0. The first request is issued the following cycle.
  - A redirect during FLUSH re-applies the redirect rule.
- Widths: counters are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH or MAX_OUTSTANDING.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- When defined:
  - Adds output instr_misalign_o (1 bit, reset 0), set the cycle after pc_i[1:0]≠0 is seen in RUN with the issue condition otherwise true.
  - No request is issued while pc_i is misaligned; pc_stall_o=1.
  - The flag is sticky until redirect_i or reset.
- When undefined: the port is absent and pc_i[1:0] are passed to imem_addr_o unchecked.

Test Plan:
- Zero-wait memory (gnt=1 always, rvalid the next cycle), PC 0x0→0x4→0x8, ready=1 → instr_valid_o first at cycle 2 with instr_pc_o=0x0; one instruction per cycle thereafter; pc_stall_o=0 in steady state.
- instr_ready_i=0 held → at most DEPTH=2 words fetched; imem_req_o drops; pc_stall_o=1; PC frozen at 0x8. Release ready → 0x0, 0x4 delivered in order and fetching resumes.
- gnt held 0 for 3 cycles with pc_i=0x100 → imem_req_o=1 and imem_addr_o=0x100 stable; pc_stall_o=1 throughout; accept on the 4th cycle.
- Two requests outstanding (0x10, 0x14), redirect to 0x80 → both late responses discarded; first request after FLUSH has imem_addr_o=0x80; next instr_pc_o=0x80.
- Reset asserted with one request outstanding, then a stray rvalid after release → ignored; instr_valid_o stays 0; fetch restarts from pc_i.
- FETCH_MISALIGN_CHECK_EN defined, pc_i=0x102 → instr_misalign_o=1 next cycle; no request; flag clears on redirect_i.
